// File: rtl/pipe_skid_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg_pkg
//   Shared definitions for the skid-buffered pipeline register.
//   - state_t : FSM encoding (EMPTY / FULL / SKID; 2'b11 is unreachable
//               and recovers to EMPTY)
//   - occ_of  : number of entries held in a given state
// ---------------------------------------------------------------------------
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,  // nothing held
        ST_FULL    = 2'b01,  // main register holds the head entry
        ST_SKID    = 2'b10,  // main + skid both hold entries
        ST_ILLEGAL = 2'b11   // never entered; recovers to EMPTY
    } state_t;

    function automatic logic [1:0] occ_of(input state_t s);
        case (s)
            ST_FULL: occ_of = 2'd1;
            ST_SKID: occ_of = 2'd2;
            default: occ_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_skid_reg_dff_en_w.sv
// ---------------------------------------------------------------------------
// dff_en_w
//   WIDTH-bit data register with load enable and asynchronous active-low
//   reset to RST_VAL.
//   Ports:
//     clk  in   1      clock (posedge)
//     rst  in   1      asynchronous active-low reset
//     en   in   1      load enable
//     d    in   WIDTH  next value
//     q    out  WIDTH  registered value
// ---------------------------------------------------------------------------
module dff_en_w #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
//   WIDTH-bit pipeline register with valid/ready on both sides and a
//   one-entry skid buffer, so in_ready comes straight from the state flop.
//   Supports a synchronous flush and counts output transfers.
//   Ports:
//     clk        in   1      clock (posedge)
//     rst        in   1      asynchronous active-low reset
//     flush      in   1      discard all held entries (synchronous)
//     in_valid   in   1      upstream data valid
//     in_ready   out  1      block can accept (decoded from state flop)
//     in_data    in   WIDTH  upstream data
//     out_valid  out  1      out_data valid (decoded from state flop)
//     out_ready  in   1      downstream accepts
//     out_data   out  WIDTH  head entry (main register)
//     occupancy  out  2      entries held: 0, 1 or 2
//     xfer_cnt   out  CNT_W  output transfers, wraps
// ---------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] xfer_cnt
);

    state_t           state;
    state_t           state_nxt;
    logic             in_fire;
    logic             out_fire;
    logic             main_en;
    logic [WIDTH-1:0] main_d;
    logic             skid_en;
    logic [WIDTH-1:0] skid_q;

    assign out_valid = (state != ST_EMPTY);
    assign in_ready  = (state != ST_SKID);
    assign occupancy = occ_of(state);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        main_en   = 1'b0;
        main_d    = in_data;
        skid_en   = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_nxt = ST_FULL;
                    main_en   = 1'b1;
                end
            end
            ST_FULL: begin
                if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
                    state_nxt = ST_SKID;
                    skid_en   = 1'b1;
                end else if (out_fire) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_SKID: begin
                // in_ready is low here, so only the drain can happen.
                if (out_fire) begin
                    state_nxt = ST_FULL;
                    main_en   = 1'b1;
                    main_d    = skid_q;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        // Flush empties the block and drops any same-cycle input; the data
        // registers keep their contents since out_valid masks them.
        if (flush) begin
            state_nxt = ST_EMPTY;
            main_en   = 1'b0;
            skid_en   = 1'b0;
        end
    end

    dff_en_w #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (out_data)
    );

    dff_en_w #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (in_data),
        .q   (skid_q)
    );

    // Counts every output transfer, including one that coincides with flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xfer_cnt <= '0;
        end else if (out_fire) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_reg
//   Self-checking bench for pipe_skid_reg (WIDTH=8, CNT_W=4, RST_VAL=A5).
//   A queue-based model of the block's contents is compared against the DUT
//   on every falling edge; directed sections add literal expectations.
// ---------------------------------------------------------------------------
module tb_pipe_skid_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [1:0] occupancy;
    logic [3:0] xfer_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Behavioural model: entries held, in order, plus transfer totals.
    logic [7:0] m_q[$];
    int         m_cnt  = 0;
    int         m_pops = 0;
    bit         m_of;
    bit         m_if;

    pipe_skid_reg #(.WIDTH(8), .RST_VAL(8'hA5), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_cnt = 0;
        end else begin
            m_of = (m_q.size() > 0) && out_ready;
            m_if = in_valid && (m_q.size() < 2);
            if (m_of) begin
                m_cnt++;
                m_pops++;
            end
            if (flush) begin
                m_q.delete();
            end else begin
                if (m_of) void'(m_q.pop_front());
                if (m_if) m_q.push_back(in_data);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_out_valid", 32'(out_valid), 32'(m_q.size() > 0));
            check("cmp_in_ready", 32'(in_ready), 32'(m_q.size() < 2));
            check("cmp_occupancy", 32'(occupancy), 32'(m_q.size()));
            check("cmp_xfer_cnt", 32'(xfer_cnt), 32'(m_cnt % 16));
            if (m_q.size() > 0) check("cmp_out_data", 32'(out_data), 32'(m_q[0]));
        end
    end

    // Apply inputs for one cycle; returns 1 time unit after the edge.
    task automatic cyc(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    int base;

    initial begin
        #1 rst = 1'b0;
        cmp_en = 1'b1;

        // Reset held three cycles.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'hA5);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
        rst = 1'b1;

        // Streaming: one word per cycle, downstream always ready.
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, 8'(i), 1'b1, 1'b0);
            check("stream_out_data", 32'(out_data), 32'(i));
            check("stream_occupancy", 32'(occupancy), 32'd1);
            check("stream_in_ready", 32'(in_ready), 32'd1);
            check("stream_xfer_cnt", 32'(xfer_cnt), 32'(i % 16));
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("drain_occupancy", 32'(occupancy), 32'd0);
        check("drain_xfer_cnt", 32'(xfer_cnt), 32'd0);

        // Backpressure fills the skid entry.
        cyc(1'b1, 8'h3C, 1'b0, 1'b0);
        cyc(1'b1, 8'h7E, 1'b0, 1'b0);
        check("bp_occupancy", 32'(occupancy), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_data", 32'(out_data), 32'h3C);
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        check("bp_hold_occ", 32'(occupancy), 32'd2);
        check("bp_hold_data", 32'(out_data), 32'h3C);
        cyc(1'b1, 8'h11, 1'b1, 1'b0);
        check("bp_second", 32'(out_data), 32'h7E);
        check("bp_second_occ", 32'(occupancy), 32'd1);
        cyc(1'b1, 8'h11, 1'b1, 1'b0);
        check("bp_third", 32'(out_data), 32'h11);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("bp_empty", 32'(occupancy), 32'd0);
        check("bp_xfer_cnt", 32'(xfer_cnt), 32'd3);

        // Flush with a simultaneous push.
        cyc(1'b1, 8'h3C, 1'b0, 1'b0);
        cyc(1'b1, 8'h7E, 1'b0, 1'b0);
        check("fl_pre_occ", 32'(occupancy), 32'd2);
        cyc(1'b1, 8'h55, 1'b0, 1'b1);
        check("fl_occupancy", 32'(occupancy), 32'd0);
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_in_ready", 32'(in_ready), 32'd1);
        repeat (3) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            check("fl_stays_empty", 32'(out_valid), 32'd0);
        end
        cyc(1'b1, 8'hAA, 1'b1, 1'b0);
        check("fl_next_data", 32'(out_data), 32'hAA);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("fl_xfer_cnt", 32'(xfer_cnt), 32'd4);

        // Asynchronous reset while two entries are held.
        cyc(1'b1, 8'h12, 1'b0, 1'b0);
        cyc(1'b1, 8'h34, 1'b0, 1'b0);
        check("ar_pre_occ", 32'(occupancy), 32'd2);
        #2 rst = 1'b0;
        #1;
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_in_ready", 32'(in_ready), 32'd1);
        check("ar_out_data", 32'(out_data), 32'hA5);
        check("ar_occupancy", 32'(occupancy), 32'd0);
        check("ar_xfer_cnt", 32'(xfer_cnt), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            check("ar_no_old_data", 32'(out_valid), 32'd0);
        end

        // Random valid/ready traffic against the model.
        base   = m_cnt;
        m_pops = 0;
        for (int i = 0; i < 500; i++) begin
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
        check("rand_xfer_cnt", 32'(xfer_cnt), 32'((base + m_pops) % 16));

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
